disc_rasterizer: RTL
====================

# disc_rasterizer

Parametrised successor to the fixed-sprite painter path. Accepts one projected particle per transaction (screen-space center, radius, depth) and scan-converts it into a filled disc: every screen pixel with dx²+dy² ≤ r² is emitted with its coordinates, framebuffer address and the particle depth. Pixels outside the WIDTH×HEIGHT screen are clipped, and the output stream supports backpressure. Sits between projection and the depth-test/framebuffer write stage.

## Interface
- WIDTH, 320, screen width in pixels
- HEIGHT, 180, screen height in pixels
- MAX_RADIUS, 31, largest radius rasterized; larger inputs are clamped
- RADIUS_W, 8, width of radius_in
- DEPTH_W, 16, width of depth_in/depth_out
- ADDR_W, $clog2(WIDTH*HEIGHT), width of addr_out
- clk_in  input  1  single clock, all logic rising-edge
- rst_n_in  input  1  asynchronous, active-low reset
- data_valid_in  input  1  particle descriptor valid
- ready_out  output  1  block can accept a descriptor
- hcount_in  input  11  center x, unsigned
- vcount_in  input  10  center y, unsigned
- radius_in  input  RADIUS_W  radius in pixels, unsigned
- depth_in  input  DEPTH_W  particle depth
- pixel_valid_out  output  1  pixel beat valid
- pixel_ready_in  input  1  downstream accepts pixel beat
- hcount_out  output  11  pixel x
- vcount_out  output  10  pixel y
- addr_out  output  ADDR_W  vcount_out*WIDTH + hcount_out
- depth_out  output  DEPTH_W  latched depth of current particle
- done_out  output  1  one-cycle pulse: particle fully rasterized

## Operation
- States: IDLE, SCAN, DRAIN, DONE. ready_out = (state == IDLE).
- IDLE: on data_valid_in && ready_out, latch center, depth, r = min(radius_in, MAX_RADIUS); set dy = dx = −r; go SCAN.
- SCAN: one candidate (dx,dy) per non-stalled cycle, row-major: dx inner from −r to r, dy outer from −r to r; K = (2r+1)² candidates.
- Candidate emitted iff dx²+dy² ≤ r² (unsigned, 2·RADIUS_W+1 bits, no overflow) and 0 ≤ cx+dx < WIDTH and 0 ≤ cy+dy < HEIGHT (signed 13-bit arithmetic). Rejected candidates consume a cycle and emit nothing.
- Output is a single register stage. Stall: pixel_valid_out && !pixel_ready_in freezes iterator and holds all outputs stable.
- After last candidate, go DRAIN; leave when output register is empty or accepted; DONE asserts done_out for one cycle, then IDLE.
- r = 0 yields exactly the center pixel (if on screen). Fully off-screen disc yields zero pixels but still full K-cycle scan and done_out.
- data_valid_in outside IDLE is ignored (not queued).

## Timing
- Reset (async assert, sync release): state IDLE, ready_out 1, pixel_valid_out 0, done_out 0, hcount_out/vcount_out/addr_out/depth_out 0. Reset mid-scan discards the particle and any pending pixel.
- Descriptor accepted at cycle N: candidate k (0-based) evaluated at N+1+k; if emitted, pixel_valid_out high at N+2+k (no stalls).
- Last candidate at N+K, done_out at N+K+2, ready_out high at N+K+3 (pixel_ready_in held high).
- Each stalled cycle delays all subsequent events by one cycle.
- Throughput: one candidate per cycle; no overlap between particles.

## Test plan
- Reset then center (10,20), r=0, depth 0x1234 -> single pixel at N+2: hcount 10, vcount 20, addr 6410, depth 0x1234; done_out at N+3; ready_out at N+4.
- Center (100,50), r=1 -> 5 pixels in order (100,49),(99,50),(100,50),(101,50),(100,51); first valid at N+3; done_out at N+11.
- Corner clip: center (0,0), r=2 -> exactly 6 pixels (0,0),(1,0),(2,0),(0,1),(1,1),(0,2); mirror at (319,179) -> (317,177)…(319,179), 6 pixels, none with x≥320 or y≥180.
- Backpressure: r=1 at (100,50), pixel_ready_in low for 3 cycles while valid -> outputs stable during stall, same 5 pixels, no duplicates, done_out delayed by 3 cycles.
- Off-screen and clamp: center (400,10), r=3 -> zero pixels, done_out at N+51; radius_in 40 with MAX_RADIUS 31 at (160,90) -> 63 pixels on row 90 (x 129..191), K = 3969.
- Async reset asserted mid-scan -> outputs and ready_out take reset values immediately; no done_out; next descriptor after release rasterizes correctly.

Source files
------------

// File: rtl/disc_rasterizer.sv
// disc_rasterizer: scan-converts one projected particle (center, radius,
// depth) into a filled, screen-clipped disc. The output is a single register
// stage with valid/ready backpressure.
module disc_rasterizer #(
   parameter int WIDTH      = 320,
   parameter int HEIGHT     = 180,
   parameter int MAX_RADIUS = 31,
   parameter int RADIUS_W   = 8,
   parameter int DEPTH_W    = 16,
   parameter int ADDR_W     = $clog2(WIDTH*HEIGHT)
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                data_valid_in,
   output logic                ready_out,
   input  logic [10:0]         hcount_in,
   input  logic [9:0]          vcount_in,
   input  logic [RADIUS_W-1:0] radius_in,
   input  logic [DEPTH_W-1:0]  depth_in,
   output logic                pixel_valid_out,
   input  logic                pixel_ready_in,
   output logic [10:0]         hcount_out,
   output logic [9:0]          vcount_out,
   output logic [ADDR_W-1:0]   addr_out,
   output logic [DEPTH_W-1:0]  depth_out,
   output logic                done_out
);

   localparam int SQ_W = 2*RADIUS_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [10:0]           cx_q, cx_d;
   logic [9:0]            cy_q, cy_d;
   logic [RADIUS_W-1:0]   r_q, r_d;
   logic [DEPTH_W-1:0]    dep_q, dep_d;
   logic signed [12:0]    dx_q, dx_d;
   logic signed [12:0]    dy_q, dy_d;
   logic                  pv_q, pv_d;
   logic [10:0]           hc_q, hc_d;
   logic [9:0]            vc_q, vc_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DEPTH_W-1:0]    pdep_q, pdep_d;
   logic                  done_q, done_d;

   logic [12:0]           adx_s, ady_s;
   logic [SQ_W-1:0]       adx_w_s, ady_w_s, r_w_s;
   logic [SQ_W-1:0]       dist_s, rsq_s;
   logic signed [12:0]    px_s, py_s;
   logic signed [12:0]    r_s13_s, neg_r_s;
   logic [RADIUS_W-1:0]   r_new_s;
   logic                  in_disc_s, on_screen_s, emit_s, stall_s, last_s;
   logic [ADDR_W-1:0]     addr_s;

   // Candidate evaluation: disc membership, screen clipping and address
   always_comb begin
      adx_s       = dx_q[12] ? 13'(13'sd0 - dx_q) : 13'(dx_q);
      ady_s       = dy_q[12] ? 13'(13'sd0 - dy_q) : 13'(dy_q);
      adx_w_s     = SQ_W'(adx_s[RADIUS_W-1:0]);
      ady_w_s     = SQ_W'(ady_s[RADIUS_W-1:0]);
      r_w_s       = SQ_W'(r_q);
      dist_s      = adx_w_s * adx_w_s + ady_w_s * ady_w_s;
      rsq_s       = r_w_s * r_w_s;
      in_disc_s   = (dist_s <= rsq_s);
      px_s        = $signed({2'b00, cx_q}) + dx_q;
      py_s        = $signed({3'b000, cy_q}) + dy_q;
      on_screen_s = !px_s[12] && (px_s < $signed(13'(WIDTH))) &&
                    !py_s[12] && (py_s < $signed(13'(HEIGHT)));
      emit_s      = in_disc_s && on_screen_s;
      addr_s      = ADDR_W'(py_s[9:0]) * ADDR_W'(WIDTH) + ADDR_W'(px_s[10:0]);
      r_s13_s     = $signed(13'(r_q));
      neg_r_s     = 13'sd0 - r_s13_s;
      last_s      = (dx_q == r_s13_s) && (dy_q == r_s13_s);
      stall_s     = pv_q && !pixel_ready_in;
      r_new_s     = (radius_in > RADIUS_W'(MAX_RADIUS)) ? RADIUS_W'(MAX_RADIUS) : radius_in;
   end

   // Next-state logic: descriptor latch, row-major iterator and output stage
   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      r_d     = r_q;
      dep_d   = dep_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      pv_d    = pv_q;
      hc_d    = hc_q;
      vc_d    = vc_q;
      addr_d  = addr_q;
      pdep_d  = pdep_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            pv_d = 1'b0;
            if (data_valid_in) begin
               cx_d    = hcount_in;
               cy_d    = vcount_in;
               r_d     = r_new_s;
               dep_d   = depth_in;
               dx_d    = 13'sd0 - $signed(13'(r_new_s));
               dy_d    = 13'sd0 - $signed(13'(r_new_s));
               state_d = SCAN;
            end else begin
               state_d = IDLE;
            end
         end
         SCAN: begin
            if (!stall_s) begin
               pv_d = emit_s;
               if (emit_s) begin
                  hc_d   = px_s[10:0];
                  vc_d   = py_s[9:0];
                  addr_d = addr_s;
                  pdep_d = dep_q;
               end else begin
                  hc_d = hc_q;
               end
               if (dx_q == r_s13_s) begin
                  dx_d = neg_r_s;
                  dy_d = dy_q + 13'sd1;
               end else begin
                  dx_d = dx_q + 13'sd1;
               end
               if (last_s) begin
                  state_d = DRAIN;
               end else begin
                  state_d = SCAN;
               end
            end else begin
               state_d = SCAN;
            end
         end
         DRAIN: begin
            // Leave once the final beat (if any) has been taken downstream
            if (!stall_s) begin
               pv_d    = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               state_d = DRAIN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            pv_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; async reset discards any particle in flight
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         cx_q    <= 11'd0;
         cy_q    <= 10'd0;
         r_q     <= '0;
         dep_q   <= '0;
         dx_q    <= 13'sd0;
         dy_q    <= 13'sd0;
         pv_q    <= 1'b0;
         hc_q    <= 11'd0;
         vc_q    <= 10'd0;
         addr_q  <= '0;
         pdep_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         r_q     <= r_d;
         dep_q   <= dep_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         pv_q    <= pv_d;
         hc_q    <= hc_d;
         vc_q    <= vc_d;
         addr_q  <= addr_d;
         pdep_q  <= pdep_d;
         done_q  <= done_d;
      end
   end

   assign ready_out       = (state_q == IDLE);
   assign pixel_valid_out = pv_q;
   assign hcount_out      = hc_q;
   assign vcount_out      = vc_q;
   assign addr_out        = addr_q;
   assign depth_out       = pdep_q;
   assign done_out        = done_q;

endmodule
